// File: rtl/mux4_rr_if.sv
// Bundle of the four source channels and the merged output stream of mux4_rr.
// The master side drives source data/valid and output ready; the slave side is the merge stage.
interface mux4_rr_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [WIDTH-1:0] in3;
    logic [3:0]       vld;
    logic [3:0]       rdy;
    logic [WIDTH-1:0] out;
    logic             out_vld;
    logic             out_rdy;
    logic [1:0]       sel;

    modport master (
        output in0, in1, in2, in3, vld, out_rdy,
        input  rdy, out, out_vld, sel
    );

    modport slave (
        input  in0, in1, in2, in3, vld, out_rdy,
        output rdy, out, out_vld, sel
    );
endinterface

// File: rtl/mux4_rr.sv
// Round-robin 4-to-1 merge stage: one registered output word tagged with its source index,
// refilled in the same cycle it drains so contention gives one word per clock.
module mux4_rr #(
    parameter int unsigned WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    mux4_rr_if.slave  bus
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;
    logic [1:0]       ptr_q;

    logic [1:0]       win;
    logic             found;
    logic             grant;
    logic [WIDTH-1:0] win_data;

    // First requester at or after the pointer, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        win   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            if (!found && bus.vld[2'(ptr_q + 2'(k))]) begin
                found = 1'b1;
                win   = 2'(ptr_q + 2'(k));
            end
        end
    end

    // The output register can take a word when empty or when it drains at this edge.
    assign grant   = found & ((state_q == EMPTY) | bus.out_rdy) & rst_n;
    assign bus.rdy = grant ? 4'(4'b0001 << win) : 4'b0000;

    always_comb begin
        win_data = bus.in0;
        case (win)
            2'd0:    win_data = bus.in0;
            2'd1:    win_data = bus.in1;
            2'd2:    win_data = bus.in2;
            default: win_data = bus.in3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (grant) begin
                        state_q <= FULL;
                        data_q  <= win_data;
                        sel_q   <= win;
                        ptr_q   <= 2'(win + 2'd1);
                    end
                end
                FULL: begin
                    if (grant) begin
                        data_q  <= win_data;
                        sel_q   <= win;
                        ptr_q   <= 2'(win + 2'd1);
                    end else if (bus.out_rdy) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.out     = data_q;
    assign bus.sel     = sel_q;
    assign bus.out_vld = (state_q == FULL);
endmodule

// File: tb/tb_mux4_rr.sv
// Scoreboard bench for mux4_rr: a driver predicts grants from a round-robin reference model
// and queues expected words; a negedge monitor checks every output word and idle hold value.
module tb_mux4_rr;
    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic [7:0] d;
        logic [1:0] s;
    } item_t;

    logic clk;
    logic rst_n;

    mux4_rr_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    errors = 0;
    int    checks = 0;
    item_t q[$];
    int    ptr_m;
    logic [7:0] last_out;
    logic [1:0] last_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] in_of(input int i);
        case (i)
            0:       return bus.in0;
            1:       return bus.in1;
            2:       return bus.in2;
            default: return bus.in3;
        endcase
    endfunction

    // Output monitor: queue head is the word that must be on out while out_vld is high.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_vld", 32'(bus.out_vld), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out", 32'(bus.out), 32'(q[0].d));
                chk("sel", 32'(bus.sel), 32'(q[0].s));
                if (bus.out_rdy) begin
                    last_out = q[0].d;
                    last_sel = q[0].s;
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_out", 32'(bus.out), 32'(last_out));
                chk("idle_sel", 32'(bus.sel), 32'(last_sel));
            end
        end
    end

    // Called at posedge+1; drives one cycle, checks rdy, updates the model at the edge.
    task automatic cycle(input logic [3:0] v, input logic ordy);
        int   win;
        logic g;
        logic [3:0] exp_rdy;
        bus.vld     = v;
        bus.out_rdy = ordy;
        win = -1;
        for (int k = 0; k < 4; k++)
            if (win < 0 && v[(ptr_m + k) % 4]) win = (ptr_m + k) % 4;
        g = (win >= 0) && (q.size() == 0 || ordy);
        exp_rdy = 4'b0000;
        if (g) exp_rdy[win] = 1'b1;
        @(negedge clk);
        chk("rdy", 32'(bus.rdy), 32'(exp_rdy));
        @(posedge clk);
        if (g) begin
            q.push_back('{d: in_of(win), s: 2'(win)});
            ptr_m = (win + 1) % 4;
        end
        #1;
    endtask

    // Asynchronous reset pulled between edges; outputs must clear at once.
    task automatic reset_mid();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out", 32'(bus.out), 32'h0);
        chk("rst_vld", 32'(bus.out_vld), 32'h0);
        chk("rst_sel", 32'(bus.sel), 32'h0);
        chk("rst_rdy", 32'(bus.rdy), 32'h0);
        q.delete();
        ptr_m    = 0;
        last_out = 8'h00;
        last_sel = 2'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_inc();
        bus.in0 = 8'h10;
        bus.in1 = 8'h11;
        bus.in2 = 8'h12;
        bus.in3 = 8'h13;
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.vld     = 4'b1111;
        bus.out_rdy = 1'b1;
        bus.in0     = 8'h00;
        bus.in1     = 8'h00;
        bus.in2     = 8'h00;
        bus.in3     = 8'h00;
        ptr_m       = 0;
        last_out    = 8'h00;
        last_sel    = 2'd0;
        #1;
        chk("por_out", 32'(bus.out), 32'h0);
        chk("por_vld", 32'(bus.out_vld), 32'h0);
        chk("por_rdy", 32'(bus.rdy), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single source on channel 2.
        bus.in2 = 8'hA5;
        cycle(4'b0100, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // Reset while FULL holding 0x5A, then release into full contention.
        reset_mid();
        bus.in0 = 8'h5A;
        cycle(4'b0001, 1'b1);
        reset_mid();
        set_inc();
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b1);

        // Backpressure on 0x11, then resume with channel 2.
        reset_mid();
        set_inc();
        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b1);
        cycle(4'b0000, 1'b1);

        // Pointer wrap after channel 3, then skip from channel 1 to 3.
        reset_mid();
        set_inc();
        for (int i = 0; i < 4; i++) cycle(4'b1111, 1'b1);
        cycle(4'b1001, 1'b1);
        cycle(4'b0010, 1'b1);
        cycle(4'b1001, 1'b1);

        // Drain to EMPTY and idle.
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b0);

        // Randomized traffic with occasional mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            bus.in0 = 8'($urandom);
            bus.in1 = 8'($urandom);
            bus.in2 = 8'($urandom);
            bus.in3 = 8'($urandom);
            if (n % 700 == 699) reset_mid();
            else cycle(4'($urandom), ($urandom_range(0, 3) != 0));
        end
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
